// File: rtl/fw_ram_clear.sv
// FW RAM clear stage: sits between the CPU interconnect and the 512x32 FW RAM.
// After reset, and on FW request, it writes zero to every RAM word. While it
// clears, the CPU is held off. When idle, CPU accesses go straight to the RAM.
module fw_ram_clear #(
  parameter int ADDR_WIDTH = 9,
  parameter int NUM_WORDS  = 512
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fw_app_mode,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done,
  input  logic                  cpu_cs,
  input  logic [3:0]            cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [31:0]           cpu_write_data,
  output logic [31:0]           cpu_read_data,
  output logic                  cpu_ready,
  output logic                  ram_cs,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_read_data,
  input  logic                  ram_ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2,
    ST_IDLE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    pending_q, pending_d;
  logic                    clear_done_q, clear_done_d;
  // Set when the final word of a sweep was written without an abort; DRAIN
  // turns it into clear_done so the flag only rises once the stale ready
  // from the last clear write has been absorbed.
  logic                    full_q, full_d;

  // State and control registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_START;
      addr_q       <= '0;
      pending_q    <= 1'b0;
      clear_done_q <= 1'b0;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      clear_done_q <= clear_done_d;
      full_q       <= full_d;
    end
  end

  // Next-state, sweep address and clear-request bookkeeping.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pending_d    = pending_q;
    clear_done_d = clear_done_q;
    full_d       = full_q;
    case (state_q)
      ST_START: begin
        state_d = fw_app_mode ? ST_IDLE : ST_CLEAR;
      end
      ST_CLEAR: begin
        addr_d = addr_q + 1'b1;
        if (fw_app_mode) begin
          // Abort: the partial sweep is abandoned and never resumed.
          state_d = ST_DRAIN;
          addr_d  = '0;
          full_d  = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_DRAIN;
          addr_d  = '0;
          full_d  = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d      = ST_IDLE;
        clear_done_d = full_q;
        full_d       = 1'b0;
      end
      ST_IDLE: begin
        if (fw_app_mode) begin
          pending_d = 1'b0;
        end else if (!cpu_cs) begin
          if (clear_req || pending_q) begin
            state_d      = ST_CLEAR;
            clear_done_d = 1'b0;
            pending_d    = 1'b0;
          end
        end else if (clear_req) begin
          // CPU access in flight: remember the request until the bus is free.
          pending_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase
    if (fw_app_mode) begin
      pending_d = 1'b0;
    end
  end

  // Bus muxing: clear writes in CLEAR, CPU pass-through in IDLE, quiet otherwise.
  always_comb begin
    busy           = (state_q != ST_IDLE);
    clear_done     = clear_done_q;
    ram_cs         = 1'b0;
    ram_we         = 4'h0;
    ram_address    = '0;
    ram_write_data = 32'h0;
    cpu_read_data  = 32'h0;
    cpu_ready      = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ram_cs         = 1'b1;
        ram_we         = 4'hf;
        ram_address    = addr_q;
        ram_write_data = 32'h0;
      end
      ST_IDLE: begin
        ram_cs         = cpu_cs;
        ram_we         = cpu_cs ? cpu_we : 4'h0;
        ram_address    = cpu_address;
        ram_write_data = cpu_write_data;
        cpu_read_data  = ram_read_data;
        cpu_ready      = ram_ready;
      end
      default: begin
      end
    endcase
  end

endmodule
